// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter grant mux.
// Optional feature macro used by this slice: ARB_MUX_LAST_LOCK_EN (packet lock until req_last).
package arb_pkg;

    localparam int NUM_CLIENTS_DEF = 4;
    // Width of the vector accepted by onehot_to_idx; bounds NUM_CLIENTS.
    localparam int OH_VEC_W        = 32;

    typedef logic [$clog2(NUM_CLIENTS_DEF)-1:0] client_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } mux_state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int onehot_to_idx(input logic [OH_VEC_W-1:0] vec);
        int idx;
        idx = 0;
        for (int i = OH_VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_skid_buf.sv
// Two-entry valid/ready skid buffer. Entry 0 is always the head; the output
// fields come straight from registers so the downstream side sees no logic.
module arb_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic [W-1:0] r_mem0;
    logic [W-1:0] r_mem1;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    // Handshake decode; ready depends only on the registered fill level.
    always_comb begin
        o_ready = (r_count != 2'd2);
        o_valid = (r_count != 2'd0);
        o_data  = r_mem0;
        w_push  = i_valid && o_ready;
        w_pop   = o_valid && i_ready;
    end

    // Storage and fill level; push/pop together keeps the count and shifts the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem0  <= {W{1'b0}};
            r_mem1  <= {W{1'b0}};
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem1 <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_data;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: rtl/arb_grant_mux.sv
// Grant-driven client mux: locks onto the arbiter's granted client, forwards
// its beats through a 2-entry skid buffer and returns per-client ready.
// Optional feature: define ARB_MUX_LAST_LOCK_EN to hold the selection until a
// beat with req_last=1 transfers (no packet interleaving). Without it the
// mux re-arbitrates after every beat. NUM_CLIENTS must be in 2..32.
module arb_grant_mux
    import arb_pkg::*;
#(
    parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int DATA_W      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          grant,
    input  logic [NUM_CLIENTS-1:0]          req_valid,
    input  logic [NUM_CLIENTS*DATA_W-1:0]   req_data,
    input  logic [NUM_CLIENTS-1:0]          req_last,
    output logic [NUM_CLIENTS-1:0]          req_ready,
    output logic                            out_valid,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_last,
    output logic [$clog2(NUM_CLIENTS)-1:0]  out_client,
    input  logic                            out_ready,
    output logic                            busy
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int BUF_W = DATA_W + 1 + IDX_W;

    mux_state_e             r_state;
    mux_state_e             w_state_nxt;
    logic [NUM_CLIENTS-1:0] r_sel;
    logic [IDX_W-1:0]       r_sel_idx;

    logic [OH_VEC_W-1:0]    w_grant_ext;
    logic [IDX_W-1:0]       w_grant_idx;
    logic [NUM_CLIENTS-1:0] w_grant_oh;
    logic                   w_grant_ok;
    logic                   w_latch;

    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [DATA_W-1:0]      w_sel_data;
    logic                   w_push;
    logic                   w_buf_ready;
    logic                   w_buf_valid;
    logic [BUF_W-1:0]       w_buf_in;
    logic [BUF_W-1:0]       w_buf_out;

    // Reduce a (possibly multi-hot) grant to its lowest client and qualify it with that client's valid.
    always_comb begin
        w_grant_ext                  = {OH_VEC_W{1'b0}};
        w_grant_ext[NUM_CLIENTS-1:0] = grant;
        w_grant_idx                  = IDX_W'(onehot_to_idx(w_grant_ext));
        w_grant_oh                   = NUM_CLIENTS'(1'b1) << w_grant_idx;
        w_grant_ok                   = (grant != {NUM_CLIENTS{1'b0}}) && req_valid[w_grant_idx];
    end

    // AND-OR mux of the selected client's fields; r_sel is one-hot or zero.
    always_comb begin
        w_sel_valid = |(req_valid & r_sel);
        w_sel_last  = |(req_last & r_sel);
        w_sel_data  = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_sel_data = w_sel_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{r_sel[i]}});
        end
    end

    // Client-side handshake: only the locked client sees ready, and only while the buffer has room.
    always_comb begin
        if ((r_state == XFER) && w_buf_ready) begin
            req_ready = r_sel;
        end else begin
            req_ready = {NUM_CLIENTS{1'b0}};
        end
        w_push   = (r_state == XFER) && w_sel_valid && w_buf_ready;
        w_buf_in = {r_sel_idx, w_sel_last, w_sel_data};
    end

    // Next-state logic: IDLE waits for a usable grant, XFER ends on a transferred beat (or last beat when locked).
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_ok) begin
                    w_state_nxt = XFER;
                    w_latch     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            XFER: begin
                if (w_push) begin
`ifdef ARB_MUX_LAST_LOCK_EN
                    if (w_sel_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = XFER;
                    end
`else
                    w_state_nxt = IDLE;
`endif
                end else begin
                    w_state_nxt = XFER;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Selection register: captured only on the IDLE->XFER edge so grant changes in XFER are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= {NUM_CLIENTS{1'b0}};
            r_sel_idx <= {IDX_W{1'b0}};
        end else if (w_latch) begin
            r_sel     <= w_grant_oh;
            r_sel_idx <= w_grant_idx;
        end else begin
            r_sel     <= r_sel;
            r_sel_idx <= r_sel_idx;
        end
    end

    arb_skid_buf #(
        .W (BUF_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_push),
        .i_data  (w_buf_in),
        .o_ready (w_buf_ready),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_out),
        .i_ready (out_ready)
    );

    // Output stream fields come directly from the buffer head registers.
    always_comb begin
        out_valid  = w_buf_valid;
        out_data   = w_buf_out[DATA_W-1:0];
        out_last   = w_buf_out[DATA_W];
        out_client = w_buf_out[BUF_W-1 -: IDX_W];
        busy       = (r_state != IDLE) || w_buf_valid;
    end

endmodule
